// File: rtl/morse_char_sequencer.sv
// Morse character sequencer: accumulates dot/dash symbols, looks each letter up in the
// synchronous Morse ROM on a gap and writes the character (plus a space on word gaps) to the FIFO.
module morse_char_sequencer #(
  parameter int unsigned MAX_SYMBOLS = 5,
  parameter logic [7:0]  SPACE_ADDR  = 8'hE0,
  parameter logic [7:0]  ERR_CHAR    = 8'h3F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot,
  input  logic       dash,
  input  logic       lg,
  input  logic       wg,
  input  logic [7:0] rom_data,
  input  logic       fifo_full,
  output logic [7:0] rom_addr,
  output logic [7:0] fifo_din,
  output logic       fifo_wr_en,
  output logic [4:0] sym_q,
  output logic [2:0] sym_count,
  output logic       busy,
  output logic       drop,
  output logic [7:0] drop_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWrite,
    StSpcLookup,
    StSpcWrite
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] sym_pat_q, sym_pat_d, sym_pat_n;
  logic [2:0] sym_cnt_q, sym_cnt_d, sym_cnt_n;
  logic       inv_q, inv_d, inv_n;
  logic       err_q, err_d;
  logic       pend_q, pend_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [7:0] din_q, din_d;
  logic       wr_q, wr_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       is_sym, gap;

  assign is_sym = dot ^ dash;
  assign gap    = lg | wg;
  assign busy   = (state_q != StIdle);

  // Symbol accumulation including any symbol arriving in this cycle.
  always_comb begin
    sym_pat_n = sym_pat_q;
    sym_cnt_n = sym_cnt_q;
    inv_n     = inv_q;
    if (is_sym) begin
      if (sym_cnt_q < 3'(MAX_SYMBOLS)) begin
        sym_pat_n = {sym_pat_q[3:0], dash};
        sym_cnt_n = sym_cnt_q + 3'd1;
      end else begin
        inv_n = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sym_pat_d  = sym_pat_n;
    sym_cnt_d  = sym_cnt_n;
    inv_d      = inv_n;
    err_d      = err_q;
    pend_d     = pend_q;
    rom_addr_d = rom_addr_q;
    din_d      = din_q;
    wr_d       = 1'b0;
    drop       = 1'b0;

    if (gap) begin
      sym_pat_d = '0;
      sym_cnt_d = '0;
      inv_d     = 1'b0;
      if (busy) begin
        drop = 1'b1;
      end else if (sym_cnt_n != 3'd0) begin
        rom_addr_d = {sym_cnt_n, sym_pat_n};
        pend_d     = wg;
        err_d      = inv_n;
        state_d    = StLookup;
      end else if (wg) begin
        rom_addr_d = SPACE_ADDR;
        state_d    = StSpcLookup;
      end
    end

    unique case (state_q)
      StIdle: ;
      StLookup: state_d = StWrite;
      StWrite: begin
        din_d = err_q ? ERR_CHAR : rom_data;
        wr_d  = ~fifo_full;
        drop  = drop | fifo_full;
        if (pend_q) begin
          rom_addr_d = SPACE_ADDR;
          pend_d     = 1'b0;
          state_d    = StSpcLookup;
        end else begin
          state_d = StIdle;
        end
      end
      StSpcLookup: state_d = StSpcWrite;
      StSpcWrite: begin
        din_d   = rom_data;
        wr_d    = ~fifo_full;
        drop    = drop | fifo_full;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sym_pat_q  <= '0;
      sym_cnt_q  <= '0;
      inv_q      <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      rom_addr_q <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sym_pat_q  <= sym_pat_d;
      sym_cnt_q  <= sym_cnt_d;
      inv_q      <= inv_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      rom_addr_q <= rom_addr_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_q;
  assign sym_q      = sym_pat_q;
  assign sym_count  = sym_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Scoreboard bench for morse_char_sequencer: directed letters/gaps push expected writes and
// drops with their cycle numbers; a negedge monitor pops and compares.
module tb_morse_char_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, dot, dash, lg, wg, fifo_full;
  logic [7:0] rom_data;
  logic [7:0] rom_addr, fifo_din, drop_count;
  logic       fifo_wr_en, busy, drop;
  logic [4:0] sym_q;
  logic [2:0] sym_count;

  always #5 clk = ~clk;

  morse_char_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dot        (dot),
    .dash       (dash),
    .lg         (lg),
    .wg         (wg),
    .rom_data   (rom_data),
    .fifo_full  (fifo_full),
    .rom_addr   (rom_addr),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .sym_q      (sym_q),
    .sym_count  (sym_count),
    .busy       (busy),
    .drop       (drop),
    .drop_count (drop_count)
  );

  // ROM model: one-cycle latency lookup.
  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    case (a)
      8'h20:   return 8'h45;
      8'hE0:   return 8'h20;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int      drop_q[$];
  int      checks = 0;
  int      failures = 0;
  int      exp_drop_count = 0;
  logic    prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe and drop pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_exp_t e;
    int      dc;
    if (fifo_wr_en) begin
      chk("wr_not_back_to_back", {31'd0, prev_wr}, 32'd0);
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got data %0h at cycle %0d, required none", fifo_din, cyc);
      end else begin
        e = wr_q.pop_front();
        chk("wr_data", {24'd0, fifo_din}, {24'd0, e.data});
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (drop) begin
      if (drop_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_drop: got drop at cycle %0d, required none", cyc);
      end else begin
        dc = drop_q.pop_front();
        chk("drop_cycle", cyc, dc);
      end
    end
    prev_wr = fifo_wr_en;
  end

  task automatic step(input logic d, input logic ds, input logic l, input logic w);
    dot  = d;
    dash = ds;
    lg   = l;
    wg   = w;
    @(posedge clk);
    #1;
    dot  = 1'b0;
    dash = 1'b0;
    lg   = 1'b0;
    wg   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_wr(input logic [7:0] data, input int c);
    wr_exp_t e;
    e.data = data;
    e.cyc  = c;
    wr_q.push_back(e);
  endtask

  task automatic exp_drop(input int c);
    drop_q.push_back(c);
    exp_drop_count++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    exp_drop_count = 0;
  endtask

  // Bounded drain: anything still queued after this never showed up.
  task automatic settle();
    idle(8);
    chk("writes_outstanding", wr_q.size(), 0);
    chk("drops_outstanding", drop_q.size(), 0);
    chk("drop_count", {24'd0, drop_count}, exp_drop_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int g;
    reset_n   = 1'b0;
    dot       = 1'b0;
    dash      = 1'b0;
    lg        = 1'b0;
    wg        = 1'b0;
    fifo_full = 1'b0;
    idle(2);
    chk("rst_rom_addr", {24'd0, rom_addr}, 0);
    chk("rst_fifo_din", {24'd0, fifo_din}, 0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sym_count", {29'd0, sym_count}, 0);
    chk("rst_drop_count", {24'd0, drop_count}, 0);
    do_reset();

    // dot dash dash, letter gap
    step(1, 0, 0, 0); idle(9);
    step(0, 1, 0, 0); idle(9);
    step(0, 1, 0, 0); idle(9);
    g = cyc;
    exp_wr(8'hC6, g + 3);
    step(0, 0, 1, 0);
    @(negedge clk);
    chk("rom_addr_ddd", {24'd0, rom_addr}, 32'h63);
    chk("sym_count_cleared", {29'd0, sym_count}, 0);
    settle();

    // dot, word gap: letter then space
    do_reset();
    step(1, 0, 0, 0); idle(3);
    g = cyc;
    exp_wr(8'h45, g + 3);
    exp_wr(8'h20, g + 5);
    step(0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("busy_wg", {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
    end
    settle();

    // six dashes: overflow writes ERR_CHAR, next letter starts fresh
    do_reset();
    repeat (6) begin
      step(0, 1, 0, 0);
      idle(2);
    end
    chk("sym_count_sat", {29'd0, sym_count}, 5);
    chk("sym_q_sat", {27'd0, sym_q}, 32'h1F);
    g = cyc;
    exp_wr(8'h3F, g + 3);
    step(0, 0, 1, 0);
    @(negedge clk);
    chk("sym_count_after_err", {29'd0, sym_count}, 0);
    settle();
    step(1, 0, 0, 0);
    chk("sym_count_next_letter", {29'd0, sym_count}, 1);
    exp_wr(8'h45, cyc + 3);
    step(0, 0, 1, 0);
    settle();

    // FIFO full: both writes become drops
    do_reset();
    fifo_full = 1'b1;
    step(0, 1, 0, 0); idle(2);
    g = cyc;
    exp_drop(g + 2);
    exp_drop(g + 4);
    step(0, 0, 0, 1);
    settle();
    fifo_full = 1'b0;

    // empty gaps: lg does nothing, wg writes a lone space
    do_reset();
    step(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_empty_lg", {31'd0, busy}, 0);
    end
    idle(1);
    g = cyc;
    exp_wr(8'h20, g + 3);
    step(0, 0, 0, 1);
    settle();

    // gap while busy is dropped and clears the new symbol
    do_reset();
    step(1, 0, 0, 0); idle(2);
    g = cyc;
    exp_wr(8'h45, g + 3);
    exp_drop(g + 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    @(negedge clk);
    chk("sym_count_busy_gap", {29'd0, sym_count}, 0);
    settle();

    // reset in cycle 2 of a lookup aborts the write
    step(1, 0, 0, 0); idle(2);
    step(0, 0, 1, 0);
    idle(1);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    exp_drop_count = 0;
    @(negedge clk);
    chk("abort_rom_addr", {24'd0, rom_addr}, 0);
    chk("abort_fifo_din", {24'd0, fifo_din}, 0);
    chk("abort_wr_en", {31'd0, fifo_wr_en}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_drop_count", {24'd0, drop_count}, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
